// File: rtl/bp_me_cce_wormhole_sender.sv
// Serializes one coherence request (header + optional block data) into wormhole flits addressed to a CCE.
// Optional BP_ME_CCE_WH_SENDER_BYPASS_EN: in idle, flit 0 is presented combinationally from the request.
//
// state  | meaning
// e_idle | no packet held; request accepted on v_i
// e_send | presenting flit cnt_r of the held packet on the link
module bp_me_cce_wormhole_sender #(
    parameter int cce_id_width_p  = 6,
    parameter int num_cols_p      = 4,
    parameter int y_offset_p      = 1,
    parameter int cord_x_width_p  = 4,
    parameter int cord_y_width_p  = 4,
    parameter int len_width_p     = 4,
    parameter int msg_hdr_width_p = 64,
    parameter int data_width_p    = 512,
    parameter int flit_width_p    = 128
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [cce_id_width_p-1:0]  cce_id_i,
    input  logic [msg_hdr_width_p-1:0] msg_hdr_i,
    input  logic [data_width_p-1:0]    data_i,
    input  logic                       data_v_i,
    input  logic                       v_i,
    output logic                       ready_o,
    output logic [flit_width_p-1:0]    link_data_o,
    output logic                       link_v_o,
    input  logic                       link_ready_i
);

    localparam int lg_cols_lp     = (num_cols_p > 1) ? $clog2(num_cols_p) : 0;
    localparam int hdr_width_lp   = cord_x_width_p + cord_y_width_p + len_width_p;
    localparam int short_bits_lp  = hdr_width_lp + msg_hdr_width_p;
    localparam int long_bits_lp   = short_bits_lp + data_width_p;
    localparam int short_flits_lp = (short_bits_lp + flit_width_p - 1) / flit_width_p;
    localparam int long_flits_lp  = (long_bits_lp + flit_width_p - 1) / flit_width_p;
    localparam int pkt_width_lp   = long_flits_lp * flit_width_p;
    localparam int cnt_width_lp   = (long_flits_lp > 1) ? $clog2(long_flits_lp) : 1;

    typedef enum logic [0:0] {
        e_idle,
        e_send
    } state_e;

    state_e state_r, state_n;

    logic [cnt_width_lp-1:0]   cnt_r, cnt_n;
    logic [cnt_width_lp-1:0]   last_r, last_n;
    logic [pkt_width_lp-1:0]   pkt_r, pkt_n;
    logic [pkt_width_lp-1:0]   pkt_in;
    logic [cnt_width_lp-1:0]   last_in;
    logic [len_width_p-1:0]    len_in;
    logic [cord_x_width_p-1:0] cord_x;
    logic [cord_y_width_p-1:0] cord_y;
    logic                      last_flit;

    logic [long_flits_lp-1:0][flit_width_p-1:0] pkt_flits;

    // CCE IDs fill a row before moving to the next, starting at mesh row y_offset_p
    assign cord_x = cord_x_width_p'(cce_id_i & cce_id_width_p'(num_cols_p - 1));
    assign cord_y = cord_y_width_p'(32'(cce_id_i >> lg_cols_lp) + 32'(y_offset_p));

    assign len_in  = data_v_i ? len_width_p'(long_flits_lp - 1)  : len_width_p'(short_flits_lp - 1);
    assign last_in = data_v_i ? cnt_width_lp'(long_flits_lp - 1) : cnt_width_lp'(short_flits_lp - 1);

    always_comb begin
        pkt_in = '0;
        pkt_in[0 +: cord_x_width_p]                            = cord_x;
        pkt_in[cord_x_width_p +: cord_y_width_p]               = cord_y;
        pkt_in[cord_x_width_p + cord_y_width_p +: len_width_p] = len_in;
        pkt_in[hdr_width_lp +: msg_hdr_width_p]                = msg_hdr_i;
        if (data_v_i) begin
            pkt_in[short_bits_lp +: data_width_p] = data_i;
        end
    end

    assign pkt_flits = pkt_r;
    assign last_flit = (cnt_r == last_r);

`ifdef BP_ME_CCE_WH_SENDER_BYPASS_EN
    logic [long_flits_lp-1:0][flit_width_p-1:0] pkt_in_flits;
    assign pkt_in_flits = pkt_in;
`endif

    always_comb begin
        state_n     = state_r;
        cnt_n       = cnt_r;
        last_n      = last_r;
        pkt_n       = pkt_r;
        ready_o     = 1'b0;
        link_v_o    = 1'b0;
        link_data_o = pkt_flits[cnt_r];

        case (state_r)
            e_idle: begin
                ready_o = 1'b1;
`ifdef BP_ME_CCE_WH_SENDER_BYPASS_EN
                link_v_o = v_i;
                if (v_i) begin
                    link_data_o = pkt_in_flits[0];
                end
`endif
                if (v_i) begin
                    pkt_n   = pkt_in;
                    cnt_n   = '0;
                    last_n  = last_in;
                    state_n = e_send;
`ifdef BP_ME_CCE_WH_SENDER_BYPASS_EN
                    // flit 0 already left through the bypass path
                    if (link_ready_i) begin
                        if (last_in == '0) begin
                            state_n = e_idle;
                        end else begin
                            cnt_n = cnt_width_lp'(1);
                        end
                    end
`endif
                end
            end

            e_send: begin
                link_v_o = 1'b1;
                ready_o  = link_ready_i & last_flit;
                if (link_ready_i) begin
                    if (last_flit) begin
                        // next request overlaps the final flit so packets run with no bubble
                        if (v_i) begin
                            pkt_n  = pkt_in;
                            cnt_n  = '0;
                            last_n = last_in;
                        end else begin
                            state_n = e_idle;
                        end
                    end else begin
                        cnt_n = cnt_r + cnt_width_lp'(1);
                    end
                end
            end

            default: state_n = e_idle;
        endcase

        if (!reset_n_i) begin
            ready_o  = 1'b0;
            link_v_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            cnt_r   <= '0;
            last_r  <= '0;
            pkt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            last_r  <= last_n;
            pkt_r   <= pkt_n;
        end
    end

endmodule

// File: tb/tb_bp_me_cce_wormhole_sender.sv
// Self-checking bench for bp_me_cce_wormhole_sender: vector table, directed corner sequences and a
// randomized phase checked against a flit-queue reference model.
module tb_bp_me_cce_wormhole_sender;

    localparam int CID_W    = 6;
    localparam int NUM_COLS = 4;
    localparam int Y_OFF    = 1;
    localparam int HDR_W    = 64;
    localparam int DATA_W   = 512;
    localparam int FLIT_W   = 128;
    localparam int PKT_W    = 640;

    logic                clk_i = 1'b0;
    logic                reset_n_i;
    logic [CID_W-1:0]    cce_id_i;
    logic [HDR_W-1:0]    msg_hdr_i;
    logic [DATA_W-1:0]   data_i;
    logic                data_v_i;
    logic                v_i;
    logic                ready_o;
    logic [FLIT_W-1:0]   link_data_o;
    logic                link_v_o;
    logic                link_ready_i;

    always #5 clk_i = ~clk_i;

    bp_me_cce_wormhole_sender #(
        .cce_id_width_p (CID_W),
        .num_cols_p     (NUM_COLS),
        .y_offset_p     (Y_OFF),
        .cord_x_width_p (4),
        .cord_y_width_p (4),
        .len_width_p    (4),
        .msg_hdr_width_p(HDR_W),
        .data_width_p   (DATA_W),
        .flit_width_p   (FLIT_W)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .cce_id_i    (cce_id_i),
        .msg_hdr_i   (msg_hdr_i),
        .data_i      (data_i),
        .data_v_i    (data_v_i),
        .v_i         (v_i),
        .ready_o     (ready_o),
        .link_data_o (link_data_o),
        .link_v_o    (link_v_o),
        .link_ready_i(link_ready_i)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Reference packet: plain arithmetic on the mapping and field layout
    function automatic logic [PKT_W-1:0] build_pkt(input logic [CID_W-1:0] id, input logic [HDR_W-1:0] hdr,
                                                   input logic [DATA_W-1:0] d, input logic dv);
        int x, y, len;
        logic [PKT_W-1:0] p;
        x   = int'(id) % NUM_COLS;
        y   = (int'(id) / NUM_COLS + Y_OFF) % 16;
        len = dv ? 4 : 0;
        p   = PKT_W'(x) | (PKT_W'(y) << 4) | (PKT_W'(len) << 8) | (PKT_W'(hdr) << 12);
        if (dv) p = p | (PKT_W'(d) << 76);
        return p;
    endfunction

    // Scoreboard: flits owed to the link, in order
    logic [FLIT_W-1:0] q[$];
    bit                prev_rst = 1'b0;
    bit                m_v, m_rdy;
    logic [PKT_W-1:0]  m_pkt;

    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            chk("rst_ready_o", PKT_W'(ready_o), PKT_W'(0));
            if (prev_rst) chk("rst_link_v_o", PKT_W'(link_v_o), PKT_W'(0));
            q.delete();
            prev_rst = 1'b1;
        end else begin
            m_v   = (q.size() != 0);
            m_rdy = (q.size() == 0) || (link_ready_i && q.size() == 1);
            chk("mon_link_v_o", PKT_W'(link_v_o), PKT_W'(m_v));
            chk("mon_ready_o", PKT_W'(ready_o), PKT_W'(m_rdy));
            if (m_v) chk("mon_flit", PKT_W'(link_data_o), PKT_W'(q[0]));
            else if (prev_rst) chk("mon_post_rst_data", PKT_W'(link_data_o), PKT_W'(0));
            if (m_v && link_ready_i) q.delete(0);
            if (v_i && m_rdy) begin
                m_pkt = build_pkt(cce_id_i, msg_hdr_i, data_i, data_v_i);
                for (int i = 0; i < (data_v_i ? 5 : 1); i++) q.push_back(m_pkt[i*FLIT_W +: FLIT_W]);
            end
            prev_rst = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_collect(input logic [CID_W-1:0] id, input logic [HDR_W-1:0] hdr,
                                input logic [DATA_W-1:0] d, input logic dv,
                                output logic [PKT_W-1:0] got, output int n, output int first);
        v_i = 1'b1; cce_id_i = id; msg_hdr_i = hdr; data_i = d; data_v_i = dv; link_ready_i = 1'b1;
        tick();
        v_i = 1'b0;
        got = '0; n = 0; first = -1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (link_v_o) begin
                if (first < 0) first = c;
                if (n < 5) got[n*FLIT_W +: FLIT_W] = link_data_o;
                n++;
            end
            tick();
        end
    endtask

    typedef struct {
        logic [CID_W-1:0] id;
        logic [HDR_W-1:0] hdr;
        logic             dv;
        logic [3:0]       ex;
        logic [3:0]       ey;
        logic [3:0]       elen;
        int               nfl;
    } vec_t;

    vec_t              vecs[6];
    logic [DATA_W-1:0] inc_data;
    logic [PKT_W-1:0]  got, exp_pkt;
    logic [FLIT_W-1:0] held;
    int                n, first;

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{6'd5,  64'hDEAD,             1'b0, 4'd1, 4'd2,  4'd0, 1};
        vecs[1] = '{6'd0,  64'h0123456789ABCDEF, 1'b1, 4'd0, 4'd1,  4'd4, 5};
        vecs[2] = '{6'd63, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd3, 4'd0,  4'd0, 1};
        vecs[3] = '{6'd14, 64'hA5A5A5A5_5A5A5A5A, 1'b1, 4'd2, 4'd4,  4'd4, 5};
        vecs[4] = '{6'd59, 64'h1,                1'b0, 4'd3, 4'd15, 4'd0, 1};
        vecs[5] = '{6'd36, 64'hCAFEF00D,         1'b1, 4'd0, 4'd10, 4'd4, 5};
        for (int b = 0; b < 64; b++) inc_data[b*8 +: 8] = 8'(b);

        // reset held 3 cycles with a request pending
        reset_n_i = 1'b0; v_i = 1'b1; cce_id_i = '0; msg_hdr_i = '0; data_i = '0;
        data_v_i = 1'b0; link_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("reset_ready_o", PKT_W'(ready_o), PKT_W'(0));
            chk("reset_link_v_o", PKT_W'(link_v_o), PKT_W'(0));
        end
        @(posedge clk_i); #1;
        reset_n_i = 1'b1; v_i = 1'b0;
        @(negedge clk_i);
        chk("post_reset_ready_o", PKT_W'(ready_o), PKT_W'(1));
        chk("post_reset_data", PKT_W'(link_data_o), PKT_W'(0));
        tick();

        // vector table
        for (int i = 0; i < 6; i++) begin
            send_collect(vecs[i].id, vecs[i].hdr, inc_data, vecs[i].dv, got, n, first);
            chk($sformatf("v%0d_nflits", i), PKT_W'(n), PKT_W'(vecs[i].nfl));
            chk($sformatf("v%0d_latency", i), PKT_W'(first), PKT_W'(0));
            chk($sformatf("v%0d_x", i), PKT_W'(got[3:0]), PKT_W'(vecs[i].ex));
            chk($sformatf("v%0d_y", i), PKT_W'(got[7:4]), PKT_W'(vecs[i].ey));
            chk($sformatf("v%0d_len", i), PKT_W'(got[11:8]), PKT_W'(vecs[i].elen));
            chk($sformatf("v%0d_hdr", i), PKT_W'(got[75:12]), PKT_W'(vecs[i].hdr));
            if (vecs[i].dv) begin
                chk($sformatf("v%0d_data", i), PKT_W'(got[76 +: DATA_W]), PKT_W'(inc_data));
                chk($sformatf("v%0d_pad", i), PKT_W'(got[639:588]), PKT_W'(0));
            end else begin
                chk($sformatf("v%0d_pad", i), PKT_W'(got[127:76]), PKT_W'(0));
            end
        end

        // link stall on flit 2
        exp_pkt = build_pkt(6'd22, 64'h5151, ~inc_data, 1'b1);
        v_i = 1'b1; cce_id_i = 6'd22; msg_hdr_i = 64'h5151; data_i = ~inc_data; data_v_i = 1'b1;
        link_ready_i = 1'b1;
        tick();
        v_i = 1'b0;
        for (int f = 0; f < 2; f++) begin
            @(negedge clk_i);
            chk($sformatf("stall_pre_flit%0d", f), PKT_W'(link_data_o), PKT_W'(exp_pkt[f*FLIT_W +: FLIT_W]));
            tick();
        end
        link_ready_i = 1'b0;
        held = link_data_o;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("stall_link_v_o", PKT_W'(link_v_o), PKT_W'(1));
            chk("stall_data_held", PKT_W'(link_data_o), PKT_W'(held));
            chk("stall_data_flit2", PKT_W'(link_data_o), PKT_W'(exp_pkt[2*FLIT_W +: FLIT_W]));
            tick();
        end
        link_ready_i = 1'b1;
        for (int f = 2; f < 5; f++) begin
            @(negedge clk_i);
            chk($sformatf("stall_post_flit%0d", f), PKT_W'(link_data_o), PKT_W'(exp_pkt[f*FLIT_W +: FLIT_W]));
            tick();
        end
        @(negedge clk_i);
        chk("stall_no_extra_flit", PKT_W'(link_v_o), PKT_W'(0));
        tick();

        // back-to-back short packets
        for (int i = 0; i < 4; i++) begin
            v_i = 1'b1; cce_id_i = 6'(i + 1); msg_hdr_i = 64'(100 + i); data_v_i = 1'b0;
            link_ready_i = 1'b1;
            @(negedge clk_i);
            chk($sformatf("b2b_ready%0d", i), PKT_W'(ready_o), PKT_W'(1));
            if (i > 0) begin
                exp_pkt = build_pkt(6'(i), 64'(99 + i), '0, 1'b0);
                chk($sformatf("b2b_v%0d", i), PKT_W'(link_v_o), PKT_W'(1));
                chk($sformatf("b2b_flit%0d", i), PKT_W'(link_data_o), PKT_W'(exp_pkt[127:0]));
            end
            tick();
        end
        v_i = 1'b0;
        @(negedge clk_i);
        exp_pkt = build_pkt(6'd4, 64'd103, '0, 1'b0);
        chk("b2b_v_last", PKT_W'(link_v_o), PKT_W'(1));
        chk("b2b_ready_last", PKT_W'(ready_o), PKT_W'(1));
        chk("b2b_flit_last", PKT_W'(link_data_o), PKT_W'(exp_pkt[127:0]));
        tick();
        @(negedge clk_i);
        chk("b2b_idle_after", PKT_W'(link_v_o), PKT_W'(0));
        tick();

        // reset during flit 2
        v_i = 1'b1; cce_id_i = 6'd7; msg_hdr_i = 64'h77; data_i = inc_data; data_v_i = 1'b1;
        tick();
        v_i = 1'b0;
        tick();
        tick();
        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_link_v_o", PKT_W'(link_v_o), PKT_W'(0));
        chk("midrst_data", PKT_W'(link_data_o), PKT_W'(0));
        tick();
        send_collect(6'd9, 64'h99, inc_data, 1'b1, got, n, first);
        chk("midrst_long_n", PKT_W'(n), PKT_W'(5));
        chk("midrst_long_len", PKT_W'(got[11:8]), PKT_W'(4));
        chk("midrst_long_x", PKT_W'(got[3:0]), PKT_W'(1));
        chk("midrst_long_y", PKT_W'(got[7:4]), PKT_W'(3));
        send_collect(6'd9, 64'h98, inc_data, 1'b0, got, n, first);
        chk("midrst_short_n", PKT_W'(n), PKT_W'(1));
        chk("midrst_short_len", PKT_W'(got[11:8]), PKT_W'(0));

        // randomized traffic against the scoreboard
        for (int c = 0; c < 2000; c++) begin
            reset_n_i    = ($urandom_range(0, 199) != 0);
            v_i          = $urandom_range(0, 1) == 1;
            link_ready_i = ($urandom_range(0, 9) < 7);
            cce_id_i     = 6'($urandom);
            data_v_i     = $urandom_range(0, 1) == 1;
            msg_hdr_i    = {$urandom, $urandom};
            for (int w = 0; w < 16; w++) data_i[w*32 +: 32] = $urandom;
            tick();
        end
        reset_n_i = 1'b1; v_i = 1'b0; link_ready_i = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        @(negedge clk_i);
        chk("drain_empty", PKT_W'(q.size()), PKT_W'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
